// File: rtl/serdes_reconfig_pkg.sv
// Shared definitions for the SERDES reconfiguration master.
// Contents: bus/field widths, command op encodings, FSM state enum, the
// timeout read-data marker and the read-modify-write merge helper.
package serdes_reconfig_pkg;

  localparam int unsigned CH_W   = 1;
  localparam int unsigned OFS_W  = 10;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    OpRead  = 2'b00,
    OpWrite = 2'b01,
    OpRmw   = 2'b10,
    OpRsvd  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCalWait = 3'd1,
    StRd      = 3'd2,
    StWr      = 3'd3,
    StResp    = 3'd4
  } state_e;

  // Returned in rsp_rdata when an access is dropped by the watchdog.
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Bits selected by mask come from the new data, the rest keep their old value.
  function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] rdata,
                                                  input logic [DATA_W-1:0] wdata,
                                                  input logic [DATA_W-1:0] mask);
    return (rdata & ~mask) | (wdata & mask);
  endfunction

  // First bus state for an op; reserved ops skip the bus and respond with an error.
  function automatic state_e first_access(input op_e op);
    state_e st;
    case (op)
      OpRead, OpRmw: st = StRd;
      OpWrite:       st = StWr;
      default:       st = StResp;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/serdes_reconfig_wdog.sv
// Access watchdog for the SERDES reconfiguration master.
// Counts consecutive stalled cycles of one bus access and flags expiry on the
// LIMIT-th one, so the master can drop the access in that same cycle.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   run      : a bus access (read or write strobe) is active this cycle
//   stall    : the slave holds waitrequest this cycle
//   expired  : this is the LIMIT-th consecutive stalled cycle
module serdes_reconfig_wdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic stall,
  output logic expired
);

  localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  // Number of stalled cycles already seen in the current access.
  logic [CntW-1:0] cnt_q;

  assign expired = run && stall && (cnt_q == CntW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (run && stall && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/serdes_reconfig_master.sv
// Command-driven Avalon-MM master for transceiver reconfiguration registers.
// Accepts read / write / read-modify-write commands, optionally holds them off
// while the target channel is calibrating, runs the bus accesses and returns a
// one-cycle response.
// Optional feature: define SERDES_RECONFIG_TIMEOUT_EN to drop accesses that
// stall for TIMEOUT_CYCLES consecutive cycles (error response, rdata DEADBEEF).
// Ports:
//   reconfig_clk, reconfig_reset     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : command handshake (ready only when idle)
//   cmd_op/ch/offset/wdata/mask      : command fields
//   cal_busy                         : per-channel calibration busy
//   reconfig_read/write/address/
//   writedata/readdata/waitrequest   : Avalon-MM master port
//   rsp_valid/rsp_rdata/rsp_err      : completion pulse, read data, error
module serdes_reconfig_master
  import serdes_reconfig_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          CAL_WAIT       = 1'b1
) (
  input  logic                reconfig_clk,
  input  logic                reconfig_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [OFS_W-1:0]    cmd_offset,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W-1:0]   cmd_mask,
  input  logic [2**CH_W-1:0]  cal_busy,
  output logic                reconfig_write,
  output logic                reconfig_read,
  output logic [ADDR_W-1:0]   reconfig_address,
  output logic [DATA_W-1:0]   reconfig_writedata,
  input  logic [DATA_W-1:0]   reconfig_readdata,
  input  logic                reconfig_waitrequest,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                err_q, err_d;
  // Turnaround cycle between the read and write halves of a read-modify-write:
  // the FSM sits in StWr with both strobes low.
  logic                gap_q, gap_d;

  logic [CH_W-1:0]     cur_ch;
  op_e                 launch_op;
  state_e              launch_st;
  logic                expired;

  assign cur_ch    = addr_q[ADDR_W-1 -: CH_W];
  // In idle the command is still on the inputs; afterwards it is latched.
  assign launch_op = (state_q == StIdle) ? op_e'(cmd_op) : op_q;
  assign launch_st = first_access(launch_op);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q;
    gap_d       = gap_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          addr_d  = {cmd_ch, cmd_offset};
          wdata_d = cmd_wdata;
          mask_d  = cmd_mask;
          err_d   = 1'b0;
          gap_d   = 1'b0;
          if (CAL_WAIT) begin
            state_d = StCalWait;
          end else begin
            state_d = launch_st;
            if (launch_st == StResp) begin
              err_d       = 1'b1;
              rsp_rdata_d = '0;
            end
          end
        end
      end

      StCalWait: begin
        if (!cal_busy[cur_ch]) begin
          state_d = launch_st;
          if (launch_st == StResp) begin
            err_d       = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      StRd: begin
        if (expired) begin
          state_d     = StResp;
          err_d       = 1'b1;
          rsp_rdata_d = TIMEOUT_RDATA;
        end else if (!reconfig_waitrequest) begin
          rdata_d = reconfig_readdata;
          if (op_q == OpRmw) begin
            wdata_d = rmw_merge(reconfig_readdata, wdata_q, mask_q);
            gap_d   = 1'b1;
            state_d = StWr;
          end else begin
            rsp_rdata_d = reconfig_readdata;
            state_d     = StResp;
          end
        end
      end

      StWr: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (expired) begin
          state_d     = StResp;
          err_d       = 1'b1;
          rsp_rdata_d = TIMEOUT_RDATA;
        end else if (!reconfig_waitrequest) begin
          state_d     = StResp;
          // A read-modify-write reports the value it found before modifying it.
          rsp_rdata_d = (op_q == OpRmw) ? rdata_q : '0;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge reconfig_clk) begin
    if (reconfig_reset) begin
      state_q     <= StIdle;
      op_q        <= OpRead;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      rdata_q     <= rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
      gap_q       <= gap_d;
    end
  end

  assign cmd_ready          = (state_q == StIdle);
  assign reconfig_read      = (state_q == StRd);
  assign reconfig_write     = (state_q == StWr) && !gap_q;
  assign reconfig_address   = addr_q;
  assign reconfig_writedata = wdata_q;
  assign rsp_valid          = (state_q == StResp);
  assign rsp_err            = (state_q == StResp) && err_q;
  assign rsp_rdata          = rsp_rdata_q;

`ifdef SERDES_RECONFIG_TIMEOUT_EN
  serdes_reconfig_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (reconfig_clk),
    .rst     (reconfig_reset),
    .run     (reconfig_read || reconfig_write),
    .stall   (reconfig_waitrequest),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

endmodule
